// File: rtl/bit_align_ctrl.sv
// Multi-lane alignment sequencer: tries auto pattern-detect on each bit_align lane,
// falls back to a manual 0..23 shift sweep, and records per-lane lock and shift.
module bit_align_ctrl #(
  parameter int NUM_LANES     = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOCK_COUNT    = 8,
  parameter int VERIFY_WINDOW = 32
) (
  input  logic                   clk,
  input  logic                   data_rst,
  input  logic                   start,
  input  logic [NUM_LANES-1:0]   lane_align_done,
  input  logic [5*NUM_LANES-1:0] lane_shift_in,
  output logic [NUM_LANES-1:0]   lane_align_start,
  output logic [NUM_LANES-1:0]   lane_align_to_fclk,
  output logic [5*NUM_LANES-1:0] lane_extra_shift,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_LANES-1:0]   lock_mask,
  output logic [5*NUM_LANES-1:0] locked_shift,
  output logic                   all_locked
);

  typedef enum logic [2:0] {
    IDLE, AUTO_SETTLE, AUTO_VERIFY, SWEEP_SETTLE, SWEEP_VERIFY, CAPTURE, NEXT, DONE
  } state_t;

  localparam int              LW          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LW-1:0]   LAST_LANE   = LW'(NUM_LANES - 1);
  localparam logic [LW-1:0]   LANE_ONE    = LW'(1);
  localparam logic [15:0]     SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0]     LOCK_TGT    = 16'(LOCK_COUNT);
  localparam logic [15:0]     WIN_TGT     = 16'(VERIFY_WINDOW);
  localparam logic [4:0]      MAX_SHIFT   = 5'd23;

  state_t         state_q, state_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [4:0]     sweep_q, sweep_d;
  logic [15:0]    settle_q, settle_d, lock_q, lock_d, win_q, win_d;
  logic           fail_lane, lane_active_d;
  logic [NUM_LANES-1:0] mask_d;
  logic [4:0]     shift_in_arr [NUM_LANES];
  logic [4:0]     extra_q      [NUM_LANES];
  logic [4:0]     locked_q     [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
    assign shift_in_arr[g]          = lane_shift_in[5*g +: 5];
    assign lane_extra_shift[5*g +: 5] = extra_q[g];
    assign locked_shift[5*g +: 5]     = locked_q[g];
  end

  always_ff @(posedge clk or posedge data_rst) begin
    if (data_rst) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      sweep_q  <= '0;
      settle_q <= '0;
      lock_q   <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      sweep_q  <= sweep_d;
      settle_q <= settle_d;
      lock_q   <= lock_d;
      win_q    <= win_d;
    end
  end

  // Success is tested before window expiry so a lock on the last window cycle wins.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    sweep_d   = sweep_q;
    settle_d  = settle_q;
    lock_d    = lock_q;
    win_d     = win_q;
    fail_lane = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = AUTO_SETTLE;
        lane_d   = '0;
        sweep_d  = '0;
        settle_d = '0;
      end
      AUTO_SETTLE, SWEEP_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = (state_q == AUTO_SETTLE) ? AUTO_VERIFY : SWEEP_VERIFY;
          settle_d = '0;
          lock_d   = '0;
          win_d    = '0;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      AUTO_VERIFY, SWEEP_VERIFY: begin
        lock_d = lane_align_done[lane_q] ? lock_q + 16'd1 : '0;
        win_d  = win_q + 16'd1;
        if (lock_d == LOCK_TGT) begin
          state_d = CAPTURE;
        end else if (win_d == WIN_TGT) begin
          settle_d = '0;
          if (state_q == AUTO_VERIFY) begin
            state_d = SWEEP_SETTLE;
            sweep_d = '0;
          end else if (sweep_q != MAX_SHIFT) begin
            state_d = SWEEP_SETTLE;
            sweep_d = sweep_q + 5'd1;
          end else begin
            state_d   = NEXT;
            fail_lane = 1'b1;
          end
        end
      end
      CAPTURE: state_d = NEXT;
      NEXT: begin
        if (lane_q == LAST_LANE) begin
          state_d = DONE;
        end else begin
          lane_d   = lane_q + LANE_ONE;
          settle_d = '0;
          state_d  = AUTO_SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mask_d        = lock_mask;
    lane_active_d = (state_d == AUTO_SETTLE) || (state_d == AUTO_VERIFY) ||
                    (state_d == SWEEP_SETTLE) || (state_d == SWEEP_VERIFY);
    if (state_q == IDLE && start)  mask_d = '0;
    else if (state_q == CAPTURE)   mask_d[lane_q] = 1'b1;
    else if (fail_lane)            mask_d[lane_q] = 1'b0;
  end

  // Outputs are registered from the next-state decode; idle lanes keep their mode/shift.
  always_ff @(posedge clk or posedge data_rst) begin
    if (data_rst) begin
      lane_align_start   <= '0;
      lane_align_to_fclk <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      lock_mask          <= '0;
      all_locked         <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        extra_q[i]  <= '0;
        locked_q[i] <= '0;
      end
    end else begin
      busy             <= (state_d != IDLE) && (state_d != DONE);
      done             <= (state_d == DONE);
      lane_align_start <= '0;
      if (lane_active_d) lane_align_start[lane_d] <= 1'b1;
      if (state_d == AUTO_SETTLE || state_d == AUTO_VERIFY) begin
        lane_align_to_fclk[lane_d] <= 1'b0;
        extra_q[lane_d]            <= '0;
      end else if (state_d == SWEEP_SETTLE || state_d == SWEEP_VERIFY) begin
        lane_align_to_fclk[lane_d] <= 1'b1;
        extra_q[lane_d]            <= sweep_d;
      end
      lock_mask  <= mask_d;
      all_locked <= &mask_d;
      if (state_q == IDLE && start) begin
        for (int i = 0; i < NUM_LANES; i++) locked_q[i] <= '0;
      end else if (state_q == CAPTURE) begin
        locked_q[lane_q] <= shift_in_arr[lane_q];
      end else if (fail_lane) begin
        locked_q[lane_q] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bit_align_ctrl.sv
// Bench for bit_align_ctrl: closed-loop bit_align lane models, a timeline model of the
// expected per-cycle outputs, plus a one-lane instance for window/lock boundary cases.
module tb_bit_align_ctrl;
  localparam int N = 4, S = 4, L = 8, W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic data_rst, start;
  logic [N-1:0]   lane_align_done, lane_align_start, lane_align_to_fclk, lock_mask;
  logic [5*N-1:0] lane_shift_in, lane_extra_shift, locked_shift;
  logic busy, done, all_locked;

  logic       s_start, s_busy, s_done, s_all;
  logic [0:0] s_lane_done, s_align_start, s_to_fclk, s_mask;
  logic [4:0] s_shift_in, s_extra, s_locked;

  bit_align_ctrl #(.NUM_LANES(N), .SETTLE_CYCLES(S), .LOCK_COUNT(L), .VERIFY_WINDOW(W)) dut (
    .clk(clk), .data_rst(data_rst), .start(start), .lane_align_done(lane_align_done),
    .lane_shift_in(lane_shift_in), .lane_align_start(lane_align_start),
    .lane_align_to_fclk(lane_align_to_fclk), .lane_extra_shift(lane_extra_shift),
    .busy(busy), .done(done), .lock_mask(lock_mask), .locked_shift(locked_shift),
    .all_locked(all_locked));

  bit_align_ctrl #(.NUM_LANES(1), .SETTLE_CYCLES(S), .LOCK_COUNT(L), .VERIFY_WINDOW(L)) dut_small (
    .clk(clk), .data_rst(data_rst), .start(s_start), .lane_align_done(s_lane_done),
    .lane_shift_in(s_shift_in), .lane_align_start(s_align_start),
    .lane_align_to_fclk(s_to_fclk), .lane_extra_shift(s_extra),
    .busy(s_busy), .done(s_done), .lock_mask(s_mask), .locked_shift(s_locked),
    .all_locked(s_all));

  typedef struct {
    logic           busy;
    logic           done;
    logic [N-1:0]   st;
    logic [N-1:0]   fclk;
    logic [5*N-1:0] sh;
    logic           chk;
  } exp_t;

  int checks = 0, failures = 0;
  int busy_cnt, done_cnt, s_busy_cnt, s_done_cnt;
  exp_t exp_q[$];
  exp_t cmp_e;

  bit         auto_ok    [N];
  int         good_shift [N];
  int         glitch_age [N];
  logic [4:0] auto_shift [N];
  logic [N-1:0]   m_fclk, exp_mask;
  logic [5*N-1:0] m_shift, exp_locked;

  int         age [N];
  logic       prev_f [N];
  logic [4:0] prev_s [N];
  logic       lm_f, lm_match;
  logic [4:0] lm_sh;
  int         s_age, s_glitch;
  logic       s_prev_f;
  logic [4:0] s_prev_s;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Lane model: align_done is high once the lane has sat >=3 cycles in a config it likes.
  initial begin
    lane_align_done = '0;
    lane_shift_in   = '0;
    for (int i = 0; i < N; i++) begin age[i] = 0; prev_f[i] = 1'b0; prev_s[i] = '0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        lm_f  = lane_align_to_fclk[i];
        lm_sh = lane_extra_shift[i*5 +: 5];
        if (!lane_align_start[i]) age[i] = 0;
        else if (age[i] == 0 || lm_f != prev_f[i] || lm_sh != prev_s[i]) age[i] = 1;
        else age[i] = age[i] + 1;
        prev_f[i] = lm_f;
        prev_s[i] = lm_sh;
        lm_match  = lm_f ? (good_shift[i] == int'(lm_sh)) : auto_ok[i];
        lane_align_done[i] = lane_align_start[i] && lm_match && age[i] >= 3 && age[i] != glitch_age[i];
        lane_shift_in[i*5 +: 5] = lm_f ? lm_sh : auto_shift[i];
      end
    end
  end

  initial begin
    s_lane_done = '0;
    s_shift_in  = '0;
    s_age = 0; s_prev_f = 1'b0; s_prev_s = '0;
    forever begin
      @(posedge clk); #1;
      if (!s_align_start[0]) s_age = 0;
      else if (s_age == 0 || s_to_fclk[0] != s_prev_f || s_extra != s_prev_s) s_age = 1;
      else s_age = s_age + 1;
      s_prev_f = s_to_fclk[0];
      s_prev_s = s_extra;
      s_lane_done[0] = s_align_start[0] && s_age >= 3 && s_age != s_glitch;
      s_shift_in = s_to_fclk[0] ? s_extra : 5'd13;
    end
  end

  // Verify cycles an attempt lasts, and whether it ends in lock.
  function automatic int attempt_len(input bit match, input int g, output bit ok);
    int run;
    run = 0;
    ok  = 1'b0;
    for (int v = 1; v <= W; v++) begin
      if (match && (S + v) != g) run++;
      else run = 0;
      if (run == L) begin ok = 1'b1; return v; end
    end
    return W;
  endfunction

  task automatic push_entry(input logic b, input logic d, input logic [N-1:0] st, input logic chk);
    exp_t e;
    e.busy = b; e.done = d; e.st = st; e.fclk = m_fclk; e.sh = m_shift; e.chk = chk;
    exp_q.push_back(e);
  endtask

  task automatic push_attempt(input int ln, input int cycles);
    logic [N-1:0] one;
    one = '0;
    one[ln] = 1'b1;
    repeat (cycles) push_entry(1'b1, 1'b0, one, 1'b0);
  endtask

  task automatic build_expected();
    bit ok;
    int v;
    exp_mask   = '0;
    exp_locked = '0;
    for (int ln = 0; ln < N; ln++) begin
      m_fclk[ln] = 1'b0;
      m_shift[ln*5 +: 5] = 5'd0;
      v = attempt_len(auto_ok[ln], glitch_age[ln], ok);
      push_attempt(ln, S + v);
      if (ok) begin
        exp_locked[ln*5 +: 5] = auto_shift[ln];
      end else begin
        for (int s = 0; s < 24 && !ok; s++) begin
          m_fclk[ln] = 1'b1;
          m_shift[ln*5 +: 5] = 5'(s);
          v = attempt_len(good_shift[ln] == s, glitch_age[ln], ok);
          push_attempt(ln, S + v);
        end
        if (ok) exp_locked[ln*5 +: 5] = 5'(good_shift[ln]);
      end
      exp_mask[ln] = ok;
      if (ok) push_entry(1'b1, 1'b0, '0, 1'b0);
      push_entry(1'b1, 1'b0, '0, 1'b0);
    end
    push_entry(1'b0, 1'b1, '0, 1'b1);
    repeat (2) push_entry(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        cmp_e = exp_q.pop_front();
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        checkOutput("busy", 64'(busy), 64'(cmp_e.busy));
        checkOutput("done", 64'(done), 64'(cmp_e.done));
        checkOutput("align_start", 64'(lane_align_start), 64'(cmp_e.st));
        checkOutput("align_to_fclk", 64'(lane_align_to_fclk), 64'(cmp_e.fclk));
        checkOutput("extra_shift", 64'(lane_extra_shift), 64'(cmp_e.sh));
        if (cmp_e.chk) begin
          checkOutput("lock_mask", 64'(lock_mask), 64'(exp_mask));
          checkOutput("locked_shift", 64'(locked_shift), 64'(exp_locked));
          checkOutput("all_locked", 64'(all_locked), 64'(&exp_mask));
        end
      end
    end
  end

  task automatic applyStimulus();
    busy_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    build_expected();
  endtask

  task automatic drain_seq(input bit mid_start);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      start = mid_start && (cyc == 20);
    end
    start = 1'b0;
    checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic set_lane(input int ln, input bit a, input int gs, input int gl, input logic [4:0] as);
    auto_ok[ln] = a; good_shift[ln] = gs; glitch_age[ln] = gl; auto_shift[ln] = as;
  endtask

  task automatic run_small(input int glitch);
    s_glitch = glitch;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    s_busy_cnt = 0;
    s_done_cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (s_busy) s_busy_cnt++;
      if (s_done) s_done_cnt++;
    end
  endtask

  initial begin
    data_rst = 1'b1; start = 1'b0; s_start = 1'b0; s_glitch = 0;
    m_fclk = '0; m_shift = '0; exp_mask = '0; exp_locked = '0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < N; i++) set_lane(i, 1'b1, -1, 0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_align_start", 64'(lane_align_start), 64'd0);
    checkOutput("rst_fclk", 64'(lane_align_to_fclk), 64'd0);
    checkOutput("rst_lock_mask", 64'(lock_mask), 64'd0);
    checkOutput("rst_locked_shift", 64'(locked_shift), 64'd0);
    checkOutput("rst_all_locked", 64'(all_locked), 64'd0);
    checkOutput("rst_small_busy", 64'(s_busy), 64'd0);
    data_rst = 1'b0;

    set_lane(0, 1'b1, -1, 0, 5'd5);
    set_lane(1, 1'b1, -1, 0, 5'd0);
    set_lane(2, 1'b1, -1, 0, 5'd17);
    set_lane(3, 1'b1, -1, 0, 5'd23);
    applyStimulus();
    drain_seq(1'b0);
    checkOutput("auto_mask", 64'(lock_mask), 64'hF);
    checkOutput("auto_shifts", 64'(locked_shift), 64'({5'd23, 5'd17, 5'd0, 5'd5}));
    checkOutput("auto_all_locked", 64'(all_locked), 64'd1);
    checkOutput("auto_busy_cycles", 64'(busy_cnt), 64'd56);
    checkOutput("auto_done_pulses", 64'(done_cnt), 64'd1);

    set_lane(1, 1'b0, 9, 0, 5'd3);
    applyStimulus();
    drain_seq(1'b1);
    checkOutput("sweep_shift1", 64'(locked_shift[9:5]), 64'd9);
    checkOutput("sweep_mask", 64'(lock_mask), 64'hF);
    checkOutput("sweep_busy_cycles", 64'(busy_cnt), 64'd416);
    checkOutput("busy_start_done_pulses", 64'(done_cnt), 64'd1);

    set_lane(1, 1'b1, -1, 0, 5'd3);
    set_lane(2, 1'b0, -1, 0, 5'd17);
    set_lane(3, 1'b1, -1, S + 6, 5'd23);
    applyStimulus();
    drain_seq(1'b0);
    checkOutput("fail_mask", 64'(lock_mask), 64'hB);
    checkOutput("fail_shift2", 64'(locked_shift[14:10]), 64'd0);
    checkOutput("fail_all_locked", 64'(all_locked), 64'd0);
    checkOutput("fail_busy_cycles", 64'(busy_cnt), 64'd949);

    set_lane(0, 1'b0, 20, 0, 5'd5);
    set_lane(2, 1'b1, -1, 0, 5'd17);
    set_lane(3, 1'b1, -1, 0, 5'd23);
    applyStimulus();
    repeat (60) @(posedge clk);
    #1;
    exp_q.delete();
    data_rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_align_start", 64'(lane_align_start), 64'd0);
    checkOutput("midrst_fclk", 64'(lane_align_to_fclk), 64'd0);
    checkOutput("midrst_extra", 64'(lane_extra_shift), 64'd0);
    checkOutput("midrst_mask", 64'(lock_mask), 64'd0);
    m_fclk = '0;
    m_shift = '0;
    @(posedge clk); #1 data_rst = 1'b0;
    applyStimulus();
    drain_seq(1'b0);
    checkOutput("restart_shift0", 64'(locked_shift[4:0]), 64'd20);
    checkOutput("restart_done_pulses", 64'(done_cnt), 64'd1);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        int gs;
        gs = int'($urandom_range(0, 31));
        set_lane(i, 1'($urandom_range(0, 1)), (gs > 23) ? -1 : gs,
                 ($urandom_range(0, 3) == 0) ? S + int'($urandom_range(1, 20)) : 0,
                 5'($urandom_range(0, 23)));
      end
      applyStimulus();
      drain_seq(r == 2);
      checkOutput("rand_done_pulses", 64'(done_cnt), 64'd1);
    end

    run_small(0);
    checkOutput("small_busy_cycles", 64'(s_busy_cnt), 64'd14);
    checkOutput("small_done_pulses", 64'(s_done_cnt), 64'd1);
    checkOutput("small_mask", 64'(s_mask), 64'd1);
    checkOutput("small_shift", 64'(s_locked), 64'd13);
    checkOutput("small_all_locked", 64'(s_all), 64'd1);
    run_small(S + 5);
    checkOutput("small_fail_busy", 64'(s_busy_cnt), 64'd301);
    checkOutput("small_fail_mask", 64'(s_mask), 64'd0);
    checkOutput("small_fail_shift", 64'(s_locked), 64'd0);
    checkOutput("small_fail_all", 64'(s_all), 64'd0);
    checkOutput("small_fail_extra", 64'(s_extra), 64'd23);
    checkOutput("small_fail_fclk", 64'(s_to_fclk), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
